// File: rtl/inc_dec_counter_if.sv
// inc_dec_counter_if: control and status bundle for the up/down counter.
interface inc_dec_counter_if #(
    parameter int WIDTH = 4
);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             up;
    logic             sat;
    logic             clr_flag;
    logic [WIDTH-1:0] count;
    logic             carry_out;
    logic             borrow_out;
    logic             ovf_sticky;
    modport master (
        output load, load_val, en, up, sat, clr_flag,
        input  count, carry_out, borrow_out, ovf_sticky
    );
    modport slave (
        input  load, load_val, en, up, sat, clr_flag,
        output count, carry_out, borrow_out, ovf_sticky
    );
endinterface

// File: rtl/inc_dec_counter.sv
// inc_dec_counter: registered up/down counter with load, saturate/wrap, wrap pulses and sticky overflow.
module inc_dec_counter #(
    parameter int WIDTH = 4
) (
    input logic              clk,
    input logic              rst,
    inc_dec_counter_if.slave bus
);
    logic [WIDTH-1:0] count_q, count_d;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH:0]   inc, dec;
    logic             step, wrap_up, wrap_dn, evt;
    always_comb begin
        inc      = {1'b0, count_q} + 1'b1;
        dec      = {1'b0, count_q} - 1'b1;
        step     = !bus.load && bus.en;
        // the incrementer's carry / decrementer's borrow mark a boundary crossing attempt
        wrap_up  = step && bus.up && inc[WIDTH];
        wrap_dn  = step && !bus.up && dec[WIDTH];
        evt      = wrap_up || wrap_dn;
        count_d  = bus.load ? bus.load_val :
                   !bus.en ? count_q :
                   (evt && bus.sat) ? count_q :
                   bus.up ? inc[WIDTH-1:0] : dec[WIDTH-1:0];
        carry_d  = wrap_up && !bus.sat;
        borrow_d = wrap_dn && !bus.sat;
        ovf_d    = evt || (ovf_q && !bus.clr_flag);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end
    assign bus.count      = count_q;
    assign bus.carry_out  = carry_q;
    assign bus.borrow_out = borrow_q;
    assign bus.ovf_sticky = ovf_q;
endmodule

// File: doc/inc_dec_counter.md
# inc_dec_counter

Registered 4-bit up/down counter that consumes the combinational incrementer (A+1 with Carry) and decrementer (A−1 with Borrow) stages. Each clock it feeds its own count back as their operand and selects one result as the next state. It adds load, enable, direction and saturate/wrap control, plus registered carry/borrow pulses and a sticky overflow flag. It is the sequential stage directly downstream of the incrementer/decrementer pair and drives the chapter's counter-based benches.

## Interface
- WIDTH, 4, counter width in bits; all arithmetic is modulo 2^WIDTH.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- load  input  1  synchronous parallel load of load_val.
- load_val  input  WIDTH  value loaded when load=1.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment (A+1), 0 = decrement (A−1).
- sat  input  1  1 = saturate at 2^WIDTH−1 / 0; 0 = wrap.
- clr_flag  input  1  clears ovf_sticky.
- count  output  WIDTH  current registered count.
- carry_out  output  1  one-cycle pulse: count wrapped from max to 0.
- borrow_out  output  1  one-cycle pulse: count wrapped from 0 to max.
- ovf_sticky  output  1  latched: an overflow or underflow event has occurred since the last clear.

## Operation
- Next-state sources: inc = {Carry, Y} = count + 1, and dec = {Borrow, Y} = count − 1. The block may instantiate the existing incrementer/decrementer stages or reproduce the same equations.
- Priority per edge is rst > load > en > hold.
- rst=1: count←0, carry_out←0, borrow_out←0, ovf_sticky←0. All other inputs are ignored.
- load=1 (rst=0): count←load_val and both pulses←0. ovf_sticky is unaffected except by clr_flag. en and up are ignored that cycle.
- en=1, up=1, no load:
  - count<max: count←count+1.
  - count=max, sat=0: count←0, carry_out←1, ovf_sticky←1.
  - count=max, sat=1: count holds at max, carry_out←0, ovf_sticky←1. A blocked attempt counts as overflow.
- en=1, up=0, no load:
  - count>0: count←count−1.
  - count=0, sat=0: count←max, borrow_out←1, ovf_sticky←1.
  - count=0, sat=1: count holds at 0, borrow_out←0, ovf_sticky←1.
- en=0, no load: count holds and both pulses←0.
- carry_out and borrow_out are never both 1.
- carry_out and borrow_out are 0 on every edge that does not produce a wrap.
- ovf_sticky:
  - clr_flag=1 with no new event that edge: ovf_sticky←0.
  - clr_flag=1 with a new event on the same edge: ovf_sticky←1 (set wins over clear).
- Internal state: count register, two pulse registers, one flag register. There is no other state.

## Timing
- All outputs are registered and change only on the rising edge of clk.
- There is no combinational path from any input to any output.
- Latency: an input sampled at edge N is reflected on count and flags immediately after edge N.
- carry_out and borrow_out are asserted for exactly the cycle in which count shows the wrapped value.
- A sustained wrap-around produces one pulse per wrap. For WIDTH=4 with en held high, that is every 16 cycles.
- Reset mid-count takes effect at the next edge:
  - count=0 after that edge.
  - Any pulse that would have fired is suppressed.
  - ovf_sticky is cleared.
- Until the first edge with rst=1, output values are undefined. Benches must assert rst for ≥1 edge before checking.

## Test plan
- Reset: hold rst for 2 edges with en=1, up=1, load=1, load_val=9 -> count=0, carry_out=0, borrow_out=0, ovf_sticky=0.
- Up wrap: after rst, en=1, up=1, sat=0 for 17 edges -> count steps 1..15 then 0. carry_out=1 only in the cycle count=0; ovf_sticky=1 from then on; count=1 on the 17th edge.
- Down wrap and saturate:
  - load load_val=0, then en=1, up=0, sat=0 for one edge -> count=15, borrow_out=1.
  - Reload 0, set sat=1, run 3 edges -> count stays 0, borrow_out=0, ovf_sticky=1.
- Priority:
  - load=1, load_val=4'hA together with en=1, up=1 -> count=10, carry_out=0.
  - Next edge, load=0 -> count=11.
  - en=0 for 3 edges -> count stays 11.
- Flag clear:
  - With ovf_sticky=1, clr_flag=1 at count=5 -> ovf_sticky=0.
  - With count=15, sat=0, up=1, en=1 and clr_flag=1 on the same edge -> count=0, carry_out=1, ovf_sticky=1.
- Reset mid-wrap: count=15, en=1, up=1 with rst=1 on the same edge -> count=0, carry_out=0, ovf_sticky=0.
